stepper_drive_seq: RTL
======================

// Module: stepper_drive_seq
// PURPOSE
//   Parametrised sequential unipolar 4-coil stepper driver, the successor to the fixed 18-bit drive block.
//   Adds a programmable step period, full-/half-step sequencing, a master enable and a signed position counter.
//   Sits between the motion-control register bank and the coil pad drivers; one instance per motor.
// PARAMETERS
//   CNT_W   18  width of the step-period prescaler and of period_i
//   POS_W   16  width of the signed position counter pos_o
// PORTS
//   clk        in   1      sole clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   enable_i   in   1      master enable; 0 = coils off, prescaler frozen
//   period_i   in   CNT_W  tick period minus one, in clk cycles
//   step_en_i  in   1      step request; latched until consumed by a tick
//   dir_i      in   1      1 = forward (phase increments), 0 = reverse
//   half_i     in   1      1 = half-step (phase +/-1), 0 = full-step (phase +/-2)
//   hold_i     in   1      1 = keep coils energised on idle ticks
//   drive_o    out  4      registered coil drive pattern
//   step_o     out  1      one-cycle pulse, the cycle after a step is taken
//   phase_o    out  3      current sequence index
//   pos_o      out  POS_W  signed step position, two's complement
//   busy_o     out  1      step request pending
// BEHAVIOUR
//   Reset values: cnt=0, phase=0, pending=0, drive_o=4'b0000, step_o=0, pos_o=0.
//   rst has priority over every other input.
//   Prescaler:
//     - tick = enable_i & (cnt >= period_i).
//     - On tick, cnt<=0; otherwise, if enable_i, cnt<=cnt+1; if !enable_i, cnt holds.
//     - The >= compare means lowering period_i below cnt fires a tick on the next enabled cycle.
//     - period_i=0 ticks every enabled cycle.
//   Request latch:
//     - pending <= step_en_i | (pending & ~tick); busy_o = pending.
//     - A request arriving in a tick cycle is not consumed by that tick; it waits for the next tick.
//   Phase table, drive_o = TBL[phase]:
//     0:0001 1:0011 2:0010 3:0110 4:0100 5:1100 6:1000 7:1001
//   On tick with pending=1 (step taken), dir_i/half_i are sampled in that cycle:
//     - delta = half_i ? 1 : 2.
//     - phase <= phase +/- delta, mod 8 (wraps 7->0 and 0->7).
//     - pos_o <= pos_o +/- delta, wrapping at POS_W bits with no saturation.
//     - drive_o <= TBL[new phase].
//     - step_o <= 1 for exactly one cycle.
//   On tick with pending=0: drive_o <= hold_i ? TBL[phase] : 4'b0000; phase and pos_o hold.
//   Between ticks, drive_o, phase_o and pos_o hold.
//   Full-step from an even phase gives wave drive (one coil); from an odd phase, two coils. No forced realignment.
//   Switching half_i or dir_i between ticks is legal; the new value takes effect at the next step.
//   enable_i=0:
//     - drive_o <= 0 on the next edge.
//     - phase, pos_o, pending and cnt are retained.
//     - Re-enable resumes counting from the retained cnt.
//   Step-to-drive latency: drive_o and step_o change 1 clk after the tick cycle.
// TESTING
//   T1 reset: rst high 2 cycles with inputs active -> drive_o=0, pos_o=0, phase_o=0, busy_o=0, step_o=0.
//   T2 half-step fwd: period_i=3, half_i=1, dir_i=1, step_en_i held 1 -> step_o every 4 clk;
//      drive_o 0011,0010,0110,... ; phase 7->0 wraps; pos_o 1,2,3,...
//   T3 full-step rev from phase 1: half_i=0, dir_i=0 -> phase 7,5,3,1; drive_o 1001,1100,0110,0011; pos_o -2,-4,...
//   T4 idle ticks: step_en_i=0 at phase 3 -> hold_i=1 gives drive_o=0110 on tick; hold_i=0 gives 0000; pos_o unchanged.
//   T5 request on tick cycle: single-cycle step_en_i coincident with tick -> no step that tick;
//      busy_o=1; step on the following tick.
//   T6 edges: POS_W=4, pos=7, fwd half -> pos_o=-8. period_i 10->2 with cnt=6 -> tick next cycle.
//      enable_i=0 mid-period -> drive_o=0, cnt frozen, resumes on re-enable.

Source files
------------

// File: rtl/stepper_drive_seq.sv
// stepper_drive_seq: programmable-period full/half-step unipolar 4-coil stepper driver with position counter
module stepper_drive_seq #(
  parameter int CNT_W = 18,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [CNT_W-1:0]        period_i,
  input  logic                    step_en_i,
  input  logic                    dir_i,
  input  logic                    half_i,
  input  logic                    hold_i,
  output logic [3:0]              drive_o,
  output logic                    step_o,
  output logic [2:0]              phase_o,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    busy_o
);
  localparam logic [31:0] TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001};
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             tick;
  logic             take;
  logic [2:0]       delta;
  logic [2:0]       next_phase;
  logic [POS_W-1:0] next_pos;
  always_comb begin
    tick       = enable_i & (cnt >= period_i);
    take       = tick & pending;
    delta      = half_i ? 3'd1 : 3'd2;
    next_phase = dir_i ? phase_o + delta : phase_o - delta;
    next_pos   = dir_i ? pos_o + POS_W'(delta) : pos_o - POS_W'(delta);
  end
  assign busy_o = pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
      phase_o <= '0;
      pos_o   <= '0;
      drive_o <= '0;
      step_o  <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : enable_i ? cnt + 1'b1 : cnt;
      pending <= step_en_i | (pending & ~tick);
      step_o  <= take;
      phase_o <= take ? next_phase : phase_o;
      pos_o   <= take ? next_pos : pos_o;
      drive_o <= !enable_i ? 4'b0000 :
                 !tick     ? drive_o :
                 take      ? TBL[{next_phase, 2'b00} +: 4] :
                 hold_i    ? TBL[{phase_o, 2'b00} +: 4] : 4'b0000;
    end
  end
endmodule
